// File: rtl/overcooked_pkg.sv
// Shared action codes and player types for the game datapath.
package overcooked_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_RIGHT = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4,
    ACT_CHOP  = 3'd5,
    ACT_CARRY = 3'd6,
    ACT_DROP  = 3'd7
  } action_t;

  typedef logic [1:0] player_id_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset back toward ptr so the nearest hit wins.
  always_comb begin
    grant_valid = |req;
    grant_idx   = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) grant_idx = idx;
    end
  end

endmodule

// File: rtl/player_action_arbiter.sv
// Serializes one action per active player per frame onto a single valid/ready port.
// Capture-to-act_valid latency 1 cycle; act_ready low holds the payload and stalls grants.
module player_action_arbiter #(
  parameter int NUM_SLOTS = overcooked_pkg::NUM_SLOTS,
  parameter int ACT_W     = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       frame_update,
  input  logic [1:0]                 num_players,
  input  logic [NUM_SLOTS-1:0]       req_valid,
  input  logic [NUM_SLOTS*ACT_W-1:0] req_action,
  output logic [NUM_SLOTS-1:0]       req_ready,
  output logic                       act_valid,
  output logic [1:0]                 act_player,
  output logic [ACT_W-1:0]           act_code,
  input  logic                       act_ready,
  output logic [NUM_SLOTS-1:0]       served,
  output logic                       overrun
);
  import overcooked_pkg::*;

  localparam int IW = $clog2(NUM_SLOTS);
  localparam logic [ACT_W-1:0] CODE_NONE = ACT_W'(ACT_NONE);

  logic [NUM_SLOTS-1:0] active;
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] capture;
  logic [NUM_SLOTS-1:0] set_pend;
  logic [NUM_SLOTS-1:0] grant_clr;
  logic [ACT_W-1:0]     hold [NUM_SLOTS];
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;
  logic                 grant_en;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active[i]   = (i <= int'(num_players));
      set_pend[i] = capture[i] && (req_action[i*ACT_W +: ACT_W] != CODE_NONE);
    end
  end

  assign req_ready = active & ~pending & ~served;
  assign capture   = req_valid & req_ready;

  // Picker sees pre-capture pending, so a fresh capture is grantable next cycle.
  rr_pick #(.N(NUM_SLOTS), .IW(IW)) u_rr_pick (
    .req        (pending & active),
    .ptr        (rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign grant_en  = grant_valid & (~act_valid | act_ready);
  assign grant_clr = grant_en ? (NUM_SLOTS'(1) << grant_idx) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      served     <= '0;
      rr_ptr     <= '0;
      act_valid  <= 1'b0;
      act_player <= '0;
      act_code   <= CODE_NONE;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) hold[i] <= '0;
    end else begin
      pending <= ((pending & ~grant_clr) | set_pend) & active;
      served  <= ((frame_update ? '0 : served) | capture) & active;
      overrun <= frame_update & ((|(pending & active)) | (act_valid & ~act_ready));
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (capture[i]) hold[i] <= req_action[i*ACT_W +: ACT_W];
      end
      // A player dropped mid-frame keeps any action already on the output.
      if (grant_en) begin
        act_valid  <= 1'b1;
        act_player <= player_id_t'(grant_idx);
        act_code   <= hold[grant_idx];
        rr_ptr     <= IW'((int'(grant_idx) + 1) % NUM_SLOTS);
      end else if (act_ready) begin
        act_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_player_action_arbiter.sv
// Scoreboard bench for player_action_arbiter: expected grants queued at stimulus, popped at handshake.
module tb_player_action_arbiter;
  import overcooked_pkg::*;

  typedef struct packed {
    logic [1:0] player;
    logic [2:0] code;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_update = 1'b0;
  logic [1:0]  num_players = 2'd0;
  logic [3:0]  req_valid = 4'd0;
  logic [11:0] req_action = 12'd0;
  logic        act_ready = 1'b0;
  logic [3:0]  req_ready;
  logic        act_valid;
  logic [1:0]  act_player;
  logic [2:0]  act_code;
  logic [3:0]  served;
  logic        overrun;

  exp_t sb[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] rr_codes [4];

  always #5 clock = ~clock;

  player_action_arbiter #(.NUM_SLOTS(4), .ACT_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .frame_update(frame_update),
    .num_players(num_players), .req_valid(req_valid), .req_action(req_action),
    .req_ready(req_ready), .act_valid(act_valid), .act_player(act_player),
    .act_code(act_code), .act_ready(act_ready), .served(served), .overrun(overrun)
  );

  // Handshake monitor: inputs settle at posedge+1, so the negedge sees the coming transfer.
  always @(negedge clock) begin
    if (reset_n && act_valid && act_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got player %0d code %0d, expected no grant", act_player, act_code);
      end else begin
        sb_e = sb.pop_front();
        if (act_player !== sb_e.player || act_code !== sb_e.code) begin
          n_err++;
          $display("FAIL sb_grant: got player %0d code %0d, expected player %0d code %0d",
                   act_player, act_code, sb_e.player, sb_e.code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int slot, input logic [2:0] code);
    req_action[slot*3 +: 3] = code;
  endtask

  task automatic push(input logic [1:0] p, input logic [2:0] c);
    sb.push_back({p, c});
  endtask

  task automatic frame_pulse();
    frame_update = 1'b1;
    tick();
    frame_update = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if (act_valid !== 1'b0 || act_player !== 2'd0 || act_code !== 3'd0 || served !== 4'd0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b p=%0d c=%0d s=%b o=%b, expected v=0 p=0 c=0 s=0000 o=0",
               act_valid, act_player, act_code, served, overrun);
    end
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_req_ready: got %b, expected 0001", req_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    num_players = 2'd1;
    act_ready   = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0011) begin
      n_err++;
      $display("FAIL basic_req_ready: got %b, expected 0011", req_ready);
    end
    set_req(0, ACT_UP);
    req_valid = 4'b0001;
    push(2'd0, ACT_UP);
    tick();
    req_valid = 4'b0000;
    n_cmp++;
    if (served !== 4'b0001 || act_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_capture: got served=%b v=%b, expected served=0001 v=0", served, act_valid);
    end
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd0 || act_code !== 3'd3) begin
      n_err++;
      $display("FAIL basic_latency: got v=%b p=%0d c=%0d, expected v=1 p=0 c=3", act_valid, act_player, act_code);
    end
    tick();
    n_cmp++;
    if (act_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle: got v=%b, expected 0", act_valid);
    end
  endtask

  task automatic test_same_frame();
    set_req(0, ACT_LEFT);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL same_frame_ready: got %b, expected 0", req_ready[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (act_valid !== 1'b0) begin
        n_err++;
        $display("FAIL same_frame_no_grant: got v=%b, expected 0", act_valid);
      end
    end
    push(2'd0, ACT_LEFT);
    frame_pulse();
    n_cmp++;
    if (req_ready[0] !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL new_frame_ready: got ready=%b overrun=%b, expected ready=1 overrun=0", req_ready[0], overrun);
    end
    tick();
    req_valid = 4'b0000;
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd0 || act_code !== 3'd1) begin
      n_err++;
      $display("FAIL new_frame_grant: got v=%b p=%0d c=%0d, expected v=1 p=0 c=1", act_valid, act_player, act_code);
    end
    tick();
  endtask

  task automatic test_round_robin();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    num_players = 2'd3;
    act_ready   = 1'b1;
    rr_codes[0] = ACT_CHOP;
    rr_codes[1] = ACT_CARRY;
    rr_codes[2] = ACT_DROP;
    rr_codes[3] = ACT_RIGHT;
    for (int i = 0; i < 4; i++) begin
      set_req(i, rr_codes[i]);
      push(i[1:0], rr_codes[i]);
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL rr_req_ready: got %b, expected 1111", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (act_valid !== 1'b1 || act_player !== i[1:0] || act_code !== rr_codes[i]) begin
        n_err++;
        $display("FAIL rr_grant: got v=%b p=%0d c=%0d, expected v=1 p=%0d c=%0d",
                 act_valid, act_player, act_code, i, rr_codes[i]);
      end
    end
    tick();
    n_cmp++;
    if (act_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rr_drain: got v=%b, expected 0", act_valid);
    end
  endtask

  task automatic test_ptr_wrap();
    frame_pulse();
    set_req(0, ACT_UP);
    set_req(3, ACT_DOWN);
    push(2'd0, ACT_UP);
    push(2'd3, ACT_DOWN);
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0000;
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd0) begin
      n_err++;
      $display("FAIL ptr_wrap_first: got v=%b p=%0d, expected v=1 p=0", act_valid, act_player);
    end
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd3 || act_code !== 3'd4) begin
      n_err++;
      $display("FAIL ptr_wrap_second: got v=%b p=%0d c=%0d, expected v=1 p=3 c=4", act_valid, act_player, act_code);
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    frame_pulse();
    act_ready = 1'b0;
    set_req(1, ACT_LEFT);
    set_req(2, ACT_RIGHT);
    push(2'd1, ACT_LEFT);
    push(2'd2, ACT_RIGHT);
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_cmp++;
      if (act_valid !== 1'b1 || act_player !== 2'd1 || act_code !== 3'd1) begin
        n_err++;
        $display("FAIL stall_stable: cycle %0d got v=%b p=%0d c=%0d, expected v=1 p=1 c=1",
                 i, act_valid, act_player, act_code);
      end
    end
    act_ready = 1'b1;
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd2 || act_code !== 3'd2) begin
      n_err++;
      $display("FAIL stall_release: got v=%b p=%0d c=%0d, expected v=1 p=2 c=2", act_valid, act_player, act_code);
    end
    tick();
  endtask

  task automatic test_shrink();
    frame_pulse();
    act_ready = 1'b0;
    set_req(0, ACT_CARRY);
    push(2'd0, ACT_CARRY);
    req_valid = 4'b0001;
    tick();
    set_req(3, ACT_DROP);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    n_cmp++;
    if (act_player !== 2'd0 || act_code !== 3'd6 || served !== 4'b1001) begin
      n_err++;
      $display("FAIL shrink_setup: got p=%0d c=%0d s=%b, expected p=0 c=6 s=1001", act_player, act_code, served);
    end
    num_players = 2'd1;
    tick();
    n_cmp++;
    if (served !== 4'b0001 || act_valid !== 1'b1 || act_player !== 2'd0) begin
      n_err++;
      $display("FAIL shrink_clear: got s=%b v=%b p=%0d, expected s=0001 v=1 p=0", served, act_valid, act_player);
    end
    act_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (act_valid !== 1'b0) begin
      n_err++;
      $display("FAIL shrink_no_grant: got v=%b p=%0d, expected v=0", act_valid, act_player);
    end
    num_players = 2'd3;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1110) begin
      n_err++;
      $display("FAIL shrink_pending_gone: got req_ready=%b, expected 1110", req_ready);
    end
  endtask

  task automatic test_overrun_reset();
    act_ready = 1'b0;
    set_req(1, ACT_UP);
    push(2'd1, ACT_UP);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    n_cmp++;
    if (act_valid !== 1'b1 || act_player !== 2'd1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_setup: got v=%b p=%0d o=%b, expected v=1 p=1 o=0", act_valid, act_player, overrun);
    end
    frame_pulse();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_pulse: got %b, expected 1", overrun);
    end
    tick();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_width: got %b, expected 0", overrun);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (act_valid !== 1'b0 || act_player !== 2'd0 || act_code !== 3'd0 || served !== 4'd0 ||
        overrun !== 1'b0 || req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL async_reset: got v=%b p=%0d c=%0d s=%b o=%b r=%b, expected v=0 p=0 c=0 s=0000 o=0 r=1111",
               act_valid, act_player, act_code, served, overrun, req_ready);
    end
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_frame();
    test_round_robin();
    test_ptr_wrap();
    test_back_to_back_stall();
    test_shrink();
    test_overrun_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d outstanding grants, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
